// File: rtl/w_icons_adc_deser.sv
// Receiver for the W_ICONS serial ADC outputs: oversamples CLK_REC/ADC_EN/data in the
// CLK_REF domain, assembles one word per ADC per frame and buffers tagged pairs in a FIFO.
module w_icons_adc_deser #(
    parameter int ADC_W   = 10,
    parameter int NCH     = 32,
    parameter int CH_W    = 5,
    parameter int FIFO_AW = 3
) (
    input  logic                 clk_i,
    input  logic                 reset_i,
    input  logic                 rec_clk_i,
    input  logic                 adc_en_i,
    input  logic                 adc1_data_i,
    input  logic                 adc2_data_i,
    input  logic                 resync_i,
    input  logic                 clear_err_i,
    output logic                 out_valid_o,
    input  logic                 out_ready_i,
    output logic [ADC_W-1:0]     out_adc1_o,
    output logic [ADC_W-1:0]     out_adc2_o,
    output logic [CH_W-1:0]      out_ch_o,
    output logic [FIFO_AW:0]     fill_o,
    output logic                 frame_err_o,
    output logic                 ovf_o
);
    // state | meaning
    // IDLE  | waiting for a frame start (armed only after adc_en seen low)
    // SHIFT | inside a frame, shifting one bit per CLK_REC rise
    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_SHIFT = 1'b1;

    localparam int BC_W  = $clog2(ADC_W + 2);
    localparam int E_W   = 2 * ADC_W + CH_W;
    localparam int DEPTH = 2 ** FIFO_AW;

    // bit order: 0 rec_clk, 1 adc_en, 2 adc1, 3 adc2
    logic [3:0]           s1_q, s1_d, s2_q, s2_d, h_q, h_d;
    logic [1:0]           flush_q, flush_d;
    logic                 armed_q, armed_d;
    logic [0:0]           state_q, state_d;
    logic [BC_W-1:0]      bit_cnt_q, bit_cnt_d;
    logic [ADC_W-1:0]     sh1_q, sh1_d, sh2_q, sh2_d;
    logic [CH_W-1:0]      ch_cnt_q, ch_cnt_d;
    logic [ADC_W-1:0]     c_adc1_q, c_adc1_d, c_adc2_q, c_adc2_d;
    logic [CH_W-1:0]      c_ch_q, c_ch_d;
    logic                 push_q, push_d;
    logic                 frame_err_q, frame_err_d, ovf_q, ovf_d;
    logic [FIFO_AW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [FIFO_AW:0]     fill_q, fill_d;
    logic [E_W-1:0]       head_q, head_d;
    logic [E_W-1:0]       mem_q [DEPTH];

    logic rise, en_rise, en_fall, close, good;
    logic full, push_ok, pop;
    logic [E_W-1:0] wdata;

    always_comb begin
        s1_d    = {adc2_data_i, adc1_data_i, adc_en_i, rec_clk_i};
        s2_d    = s1_q;
        h_d     = s2_q;
        flush_d = (flush_q == 2'd3) ? flush_q : flush_q + 2'd1;
        // A frame already running when reset releases must not look like a start.
        armed_d = armed_q | ((flush_q == 2'd3) & ~s2_q[1]);
        rise    = s2_q[0] & ~h_q[0];
        en_rise = s2_q[1] & ~h_q[1] & armed_q;
        en_fall = ~s2_q[1] & h_q[1];
    end

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        sh1_d     = sh1_q;
        sh2_d     = sh2_q;
        close     = 1'b0;
        good      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (en_rise) begin
                    bit_cnt_d = '0;
                    state_d   = ST_SHIFT;
                end
            end
            default: begin
                if (rise) begin
                    sh1_d = {sh1_q[ADC_W-2:0], s2_q[2]};
                    sh2_d = {sh2_q[ADC_W-2:0], s2_q[3]};
                    if (bit_cnt_q != BC_W'(ADC_W + 1)) bit_cnt_d = bit_cnt_q + BC_W'(1);
                end
                if (en_fall) begin
                    state_d = ST_IDLE;
                    close   = 1'b1;
                    good    = (bit_cnt_d == BC_W'(ADC_W));
                end
            end
        endcase

        c_adc1_d = c_adc1_q;
        c_adc2_d = c_adc2_q;
        c_ch_d   = c_ch_q;
        push_d   = close & good;
        if (close) begin
            c_adc1_d = sh1_d;
            c_adc2_d = sh2_d;
            c_ch_d   = ch_cnt_q;
        end

        ch_cnt_d = ch_cnt_q;
        if (resync_i)   ch_cnt_d = '0;
        else if (close) ch_cnt_d = (ch_cnt_q == CH_W'(NCH - 1)) ? '0 : ch_cnt_q + CH_W'(1);

        frame_err_d = (frame_err_q & ~clear_err_i) | (close & ~good);
    end

    always_comb begin
        wdata    = {c_adc1_q, c_adc2_q, c_ch_q};
        full     = (fill_q == (FIFO_AW+1)'(DEPTH));
        push_ok  = push_q & ~full;
        pop      = (fill_q != '0) & out_ready_i;
        wr_ptr_d = push_ok ? wr_ptr_q + FIFO_AW'(1) : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + FIFO_AW'(1) : rd_ptr_q;
        fill_d   = fill_q;
        case ({push_ok, pop})
            2'b10:   fill_d = fill_q + (FIFO_AW+1)'(1);
            2'b01:   fill_d = fill_q - (FIFO_AW+1)'(1);
            default: fill_d = fill_q;
        endcase
        ovf_d = (ovf_q & ~clear_err_i) | (push_q & full);
        // Registered head: holds the last value once the FIFO drains.
        head_d = head_q;
        if (fill_d != '0) begin
            if (push_ok && (rd_ptr_d == wr_ptr_q)) head_d = wdata;
            else                                   head_d = mem_q[rd_ptr_d];
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_ok) mem_q[wr_ptr_q] <= wdata;
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            s1_q        <= '0;
            s2_q        <= '0;
            h_q         <= '0;
            flush_q     <= '0;
            armed_q     <= 1'b0;
            state_q     <= ST_IDLE;
            bit_cnt_q   <= '0;
            sh1_q       <= '0;
            sh2_q       <= '0;
            ch_cnt_q    <= '0;
            c_adc1_q    <= '0;
            c_adc2_q    <= '0;
            c_ch_q      <= '0;
            push_q      <= 1'b0;
            frame_err_q <= 1'b0;
            ovf_q       <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            fill_q      <= '0;
            head_q      <= '0;
        end else begin
            s1_q        <= s1_d;
            s2_q        <= s2_d;
            h_q         <= h_d;
            flush_q     <= flush_d;
            armed_q     <= armed_d;
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            sh1_q       <= sh1_d;
            sh2_q       <= sh2_d;
            ch_cnt_q    <= ch_cnt_d;
            c_adc1_q    <= c_adc1_d;
            c_adc2_q    <= c_adc2_d;
            c_ch_q      <= c_ch_d;
            push_q      <= push_d;
            frame_err_q <= frame_err_d;
            ovf_q       <= ovf_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            fill_q      <= fill_d;
            head_q      <= head_d;
        end
    end

    assign out_valid_o = (fill_q != '0);
    assign fill_o      = fill_q;
    assign out_adc1_o  = head_q[E_W-1 -: ADC_W];
    assign out_adc2_o  = head_q[CH_W +: ADC_W];
    assign out_ch_o    = head_q[CH_W-1:0];
    assign frame_err_o = frame_err_q;
    assign ovf_o       = ovf_q;

endmodule

// File: tb/tb_w_icons_adc_deser.sv
// Directed bench for w_icons_adc_deser: framing, tagging, errors, overflow, resync, reset.
module tb_w_icons_adc_deser;
    logic       clk_i = 1'b0;
    logic       reset_i = 1'b1;
    logic       rec_clk_i = 1'b0, adc_en_i = 1'b0, adc1_data_i = 1'b0, adc2_data_i = 1'b0;
    logic       resync_i = 1'b0, clear_err_i = 1'b0, out_ready_i = 1'b0;
    logic       out_valid_o, frame_err_o, ovf_o;
    logic [9:0] out_adc1_o, out_adc2_o;
    logic [4:0] out_ch_o;
    logic [3:0] fill_o;

    int n_cmp = 0;
    int n_err = 0;
    logic [24:0] popped[$];

    w_icons_adc_deser dut (
        .clk_i(clk_i), .reset_i(reset_i), .rec_clk_i(rec_clk_i), .adc_en_i(adc_en_i),
        .adc1_data_i(adc1_data_i), .adc2_data_i(adc2_data_i), .resync_i(resync_i),
        .clear_err_i(clear_err_i), .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
        .out_adc1_o(out_adc1_o), .out_adc2_o(out_adc2_o), .out_ch_o(out_ch_o),
        .fill_o(fill_o), .frame_err_o(frame_err_o), .ovf_o(ovf_o)
    );

    always #5 clk_i = ~clk_i;

    always @(negedge clk_i)
        if (!reset_i && out_valid_o && out_ready_i)
            popped.push_back({out_adc1_o, out_adc2_o, out_ch_o});

    task automatic cyc();
        @(posedge clk_i); #1;
    endtask

    task automatic do_reset();
        reset_i = 1'b1;
        repeat (3) cyc();
        reset_i = 1'b0;
        repeat (4) cyc();
        popped.delete();
    endtask

    // CLK_REC = clk/8, data set up 2 cycles before each rising edge
    task automatic drive_bits(input logic [9:0] a1, input logic [9:0] a2, input int nbits);
        logic [9:0] v1, v2;
        v1 = a1; v2 = a2;
        adc_en_i = 1'b1; rec_clk_i = 1'b0;
        repeat (4) cyc();
        for (int i = 0; i < nbits; i++) begin
            adc1_data_i = (i < 10) ? v1[9-i] : 1'b0;
            adc2_data_i = (i < 10) ? v2[9-i] : 1'b0;
            repeat (2) cyc();
            rec_clk_i = 1'b1;
            repeat (4) cyc();
            rec_clk_i = 1'b0;
            repeat (2) cyc();
        end
    endtask

    task automatic end_frame();
        adc_en_i = 1'b0;
        repeat (8) cyc();
    endtask

    task automatic send_frame(input logic [9:0] a1, input logic [9:0] a2, input int nbits);
        drive_bits(a1, a2, nbits);
        end_frame();
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++; if (out_valid_o !== 1'b0) begin n_err++; $display("FAIL reset_valid got %b want 0", out_valid_o); end
        n_cmp++; if (fill_o !== 4'd0) begin n_err++; $display("FAIL reset_fill got %0d want 0", fill_o); end
        n_cmp++; if (frame_err_o !== 1'b0 || ovf_o !== 1'b0) begin n_err++; $display("FAIL reset_flags got %b%b want 00", frame_err_o, ovf_o); end
        n_cmp++; if ({out_adc1_o, out_adc2_o, out_ch_o} !== 25'd0) begin n_err++; $display("FAIL reset_outs got %h want 0", {out_adc1_o, out_adc2_o, out_ch_o}); end
    endtask

    task automatic test_first_frame();
        logic v4, v5;
        do_reset();
        out_ready_i = 1'b0;
        drive_bits(10'h2A5, 10'h15A, 10);
        adc_en_i = 1'b0;
        v4 = 1'bx; v5 = 1'bx;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk_i);
            if (k == 4) v4 = out_valid_o;
            if (k == 5) v5 = out_valid_o;
        end
        n_cmp++; if (v4 !== 1'b0 || v5 !== 1'b1) begin n_err++; $display("FAIL first_latency got %b%b want 01", v4, v5); end
        repeat (4) cyc();
        n_cmp++; if (fill_o !== 4'd1) begin n_err++; $display("FAIL first_fill got %0d want 1", fill_o); end
        n_cmp++; if (out_adc1_o !== 10'h2A5) begin n_err++; $display("FAIL first_adc1 got %h want 2a5", out_adc1_o); end
        n_cmp++; if (out_adc2_o !== 10'h15A) begin n_err++; $display("FAIL first_adc2 got %h want 15a", out_adc2_o); end
        n_cmp++; if (out_ch_o !== 5'd0) begin n_err++; $display("FAIL first_ch got %0d want 0", out_ch_o); end
        out_ready_i = 1'b1;
        repeat (3) cyc();
        n_cmp++; if (fill_o !== 4'd0 || out_valid_o !== 1'b0) begin n_err++; $display("FAIL first_pop fill %0d valid %b want 0 0", fill_o, out_valid_o); end
        n_cmp++; if (out_adc1_o !== 10'h2A5) begin n_err++; $display("FAIL first_hold got %h want 2a5", out_adc1_o); end
    endtask

    task automatic test_tag_wrap();
        logic [9:0] a1, a2;
        do_reset();
        out_ready_i = 1'b1;
        for (int i = 0; i < 33; i++) begin
            a1 = 10'((i * 37 + 5) % 1024);
            a2 = 10'((i * 13) ^ 10'h155);
            send_frame(a1, a2, 10);
        end
        n_cmp++; if (popped.size() != 33) begin n_err++; $display("FAIL wrap_count got %0d want 33", popped.size()); end
        for (int i = 0; i < 33 && i < popped.size(); i++) begin
            a1 = 10'((i * 37 + 5) % 1024);
            a2 = 10'((i * 13) ^ 10'h155);
            n_cmp++;
            if (popped[i] !== {a1, a2, 5'(i % 32)}) begin
                n_err++; $display("FAIL wrap_entry%0d got %h want %h", i, popped[i], {a1, a2, 5'(i % 32)});
            end
        end
        n_cmp++; if (frame_err_o !== 1'b0 || ovf_o !== 1'b0) begin n_err++; $display("FAIL wrap_flags got %b%b want 00", frame_err_o, ovf_o); end
    endtask

    task automatic test_frame_err();
        do_reset();
        out_ready_i = 1'b1;
        send_frame(10'h3FF, 10'h3FF, 9);
        send_frame(10'h3FF, 10'h3FF, 11);
        n_cmp++; if (popped.size() != 0) begin n_err++; $display("FAIL err_dropped got %0d entries want 0", popped.size()); end
        n_cmp++; if (frame_err_o !== 1'b1) begin n_err++; $display("FAIL err_flag got %b want 1", frame_err_o); end
        send_frame(10'h123, 10'h321, 10);
        n_cmp++; if (popped.size() != 1 || popped[0] !== {10'h123, 10'h321, 5'd2}) begin n_err++; $display("FAIL err_next got %h want %h", popped.size() ? popped[0] : 25'h0, {10'h123, 10'h321, 5'd2}); end
        clear_err_i = 1'b1; cyc(); clear_err_i = 1'b0; cyc();
        n_cmp++; if (frame_err_o !== 1'b0) begin n_err++; $display("FAIL err_clear got %b want 0", frame_err_o); end
    endtask

    task automatic test_overflow();
        do_reset();
        out_ready_i = 1'b0;
        for (int i = 0; i < 9; i++) send_frame(10'(i + 16), 10'(i + 32), 10);
        n_cmp++; if (fill_o !== 4'd8) begin n_err++; $display("FAIL ovf_fill got %0d want 8", fill_o); end
        n_cmp++; if (ovf_o !== 1'b1) begin n_err++; $display("FAIL ovf_flag got %b want 1", ovf_o); end
        out_ready_i = 1'b1;
        repeat (12) cyc();
        n_cmp++; if (popped.size() != 8) begin n_err++; $display("FAIL ovf_drain got %0d want 8", popped.size()); end
        for (int i = 0; i < 8 && i < popped.size(); i++) begin
            n_cmp++;
            if (popped[i] !== {10'(i + 16), 10'(i + 32), 5'(i)}) begin
                n_err++; $display("FAIL ovf_entry%0d got %h want %h", i, popped[i], {10'(i + 16), 10'(i + 32), 5'(i)});
            end
        end
        clear_err_i = 1'b1; cyc(); clear_err_i = 1'b0; cyc();
        n_cmp++; if (ovf_o !== 1'b0) begin n_err++; $display("FAIL ovf_clear got %b want 0", ovf_o); end
        popped.delete();
        send_frame(10'h0F0, 10'h00F, 10);
        n_cmp++; if (popped.size() != 1 || popped[0] !== {10'h0F0, 10'h00F, 5'd9}) begin n_err++; $display("FAIL ovf_next got %h want %h", popped.size() ? popped[0] : 25'h0, {10'h0F0, 10'h00F, 5'd9}); end
    endtask

    task automatic test_resync();
        do_reset();
        out_ready_i = 1'b1;
        for (int i = 0; i < 5; i++) send_frame(10'h001, 10'h002, 10);
        popped.delete();
        drive_bits(10'h2AA, 10'h155, 10);
        adc_en_i = 1'b0;
        cyc(); cyc();
        resync_i = 1'b1; cyc(); resync_i = 1'b0;
        repeat (8) cyc();
        send_frame(10'h3C3, 10'h03C, 10);
        n_cmp++; if (popped.size() != 2) begin n_err++; $display("FAIL resync_count got %0d want 2", popped.size()); end
        n_cmp++; if (popped.size() > 0 && popped[0] !== {10'h2AA, 10'h155, 5'd5}) begin n_err++; $display("FAIL resync_same got %h want %h", popped[0], {10'h2AA, 10'h155, 5'd5}); end
        n_cmp++; if (popped.size() > 1 && popped[1] !== {10'h3C3, 10'h03C, 5'd0}) begin n_err++; $display("FAIL resync_next got %h want %h", popped[1], {10'h3C3, 10'h03C, 5'd0}); end
    endtask

    task automatic test_reset_mid_frame();
        do_reset();
        out_ready_i = 1'b1;
        send_frame(10'h111, 10'h222, 10);
        drive_bits(10'h3FF, 10'h3FF, 4);
        do_reset();
        drive_bits(10'h3FF, 10'h3FF, 6);
        end_frame();
        n_cmp++; if (popped.size() != 0) begin n_err++; $display("FAIL midrst_entries got %0d want 0", popped.size()); end
        n_cmp++; if (frame_err_o !== 1'b0) begin n_err++; $display("FAIL midrst_err got %b want 0", frame_err_o); end
        send_frame(10'h0AB, 10'h1CD, 10);
        n_cmp++; if (popped.size() != 1 || popped[0] !== {10'h0AB, 10'h1CD, 5'd0}) begin n_err++; $display("FAIL midrst_next got %h want %h", popped.size() ? popped[0] : 25'h0, {10'h0AB, 10'h1CD, 5'd0}); end
    endtask

    initial begin
        test_reset();
        test_first_frame();
        test_tag_wrap();
        test_frame_err();
        test_overflow();
        test_resync();
        test_reset_mid_frame();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
